// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the stall/bubble controller: FSM encoding,
// default scoreboard geometry and the stall counter width.
package hazard_stall_ctrl_pkg;
  localparam int REG_W_DEF   = 3;
  localparam int DEPTH_DEF   = 3;
  localparam int STALL_CNT_W = 16;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_e;
endpackage

// File: rtl/hazard_stall_ctrl_sb_entry.sv
// One scoreboard slot {v, rd}: async active-low clear, frozen while hold_i.
module sb_entry #(
  parameter int REG_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold_i,
  input  logic             v_d_i,
  input  logic [REG_W-1:0] rd_d_i,
  output logic             v_q_o,
  output logic [REG_W-1:0] rd_q_o
);
  // Capture the upstream slot unless the pipe is frozen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q_o  <= 1'b0;
      rd_q_o <= '0;
    end else if (!hold_i) begin
      v_q_o  <= v_d_i;
      rd_q_o <= rd_d_i;
    end
  end
endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/bubble generator for the non-forwarding pipeline. Tracks in-flight
// destinations (EX..WB), stalls decode on RAW hazards or memory busy, drains
// the pipe after HALT and counts stalled cycles.
// Optional macro HAZARD_WB_BYPASS_EN: ignore the WB slot in hazard detection
// because the register file writes in the first half-cycle.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int REG_W = REG_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic [REG_W-1:0]       id_rs,
  input  logic [REG_W-1:0]       id_rt,
  input  logic                   id_rs_used,
  input  logic                   id_rt_used,
  input  logic [REG_W-1:0]       id_rd,
  input  logic                   id_wr_en,
  input  logic                   id_halt,
  input  logic                   mem_busy,
  output logic                   Stall,
  output logic                   bubble,
  output logic                   halt_done,
  output logic [STALL_CNT_W-1:0] stall_cnt
);
  localparam int DCW = $clog2(DEPTH + 1);
`ifdef HAZARD_WB_BYPASS_EN
  localparam int CMP_N = DEPTH - 1;
`else
  localparam int CMP_N = DEPTH;
`endif

  logic [DEPTH-1:0]            sb_v, sb_v_d;
  logic [DEPTH-1:0][REG_W-1:0] sb_rd, sb_rd_d;
  state_e                      state_q;
  logic [DCW-1:0]              drain_q;
  logic                        halt_done_q;
  logic [STALL_CNT_W-1:0]      stall_cnt_q;
  logic                        hazard, run, issue;

  // RAW check of the decode sources against every compared in-flight slot.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < CMP_N; i++) begin
      if (sb_v[i] && ((id_rs_used && (id_rs == sb_rd[i])) ||
                      (id_rt_used && (id_rt == sb_rd[i]))))
        hazard = 1'b1;
    end
    hazard = hazard & id_valid;
  end

  assign run    = (state_q == RUN);
  assign Stall  = mem_busy | hazard | ~run;
  // A frozen ID/EX must not be overwritten with a NOP.
  assign bubble = ~mem_busy & (hazard | ~run);
  assign issue  = id_valid & id_wr_en & ~hazard & run;

  // Scoreboard shift chain: slot 0 = EX, slot DEPTH-1 = WB.
  for (genvar g = 0; g < DEPTH; g++) begin : g_sb
    if (g == 0) begin : g_head
      assign sb_v_d[g]  = issue;
      assign sb_rd_d[g] = issue ? id_rd : '0;
    end else begin : g_tail
      assign sb_v_d[g]  = sb_v[g-1];
      assign sb_rd_d[g] = sb_rd[g-1];
    end
    sb_entry #(.REG_W(REG_W)) u_sb (
      .clk    (clk),
      .rst    (rst),
      .hold_i (mem_busy),
      .v_d_i  (sb_v_d[g]),
      .rd_d_i (sb_rd_d[g]),
      .v_q_o  (sb_v[g]),
      .rd_q_o (sb_rd[g])
    );
  end

  // Halt FSM: accept HALT only when decode would advance, then drain DEPTH
  // unfrozen cycles before flagging completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      drain_q     <= '0;
      halt_done_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: if (id_valid && id_halt && !Stall) begin
          state_q <= DRAIN;
          drain_q <= DCW'(DEPTH);
        end
        DRAIN: if (!mem_busy) begin
          if (drain_q == DCW'(1)) begin
            state_q     <= HALTED;
            halt_done_q <= 1'b1;
            drain_q     <= '0;
          end else begin
            drain_q <= drain_q - DCW'(1);
          end
        end
        HALTED: ;
        default: state_q <= RUN;
      endcase
    end
  end

  // Saturating count of every stalled cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cnt_q <= '0;
    else if (Stall && (stall_cnt_q != '1))
      stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
  end

  assign halt_done = halt_done_q;
  assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl.
module tb_hazard_stall_ctrl;
`ifdef HAZARD_WB_BYPASS_EN
  localparam int EXP = 2;
`else
  localparam int EXP = 3;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        id_valid = 0, id_rs_used = 0, id_rt_used = 0, id_wr_en = 0, id_halt = 0;
  logic [2:0]  id_rs = 0, id_rt = 0, id_rd = 0;
  logic        mem_busy = 0;
  logic        Stall, bubble, halt_done;
  logic [15:0] stall_cnt;
  int          ncmp = 0, nerr = 0;

  hazard_stall_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd),
    .id_wr_en(id_wr_en), .id_halt(id_halt), .mem_busy(mem_busy),
    .Stall(Stall), .bubble(bubble), .halt_done(halt_done), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_id(input logic v, input logic [2:0] rs, input logic rsu,
                        input logic [2:0] rt, input logic rtu, input logic [2:0] rd,
                        input logic wr, input logic h);
    id_valid = v; id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
    id_rd = rd; id_wr_en = wr; id_halt = h;
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_stall", Stall, 0);
    chk("rst_bubble", bubble, 0);
    chk("rst_cnt", stall_cnt, 0);
    chk("rst_hdone", halt_done, 0);
    rst = 1'b1;
    tick();

    // Back-to-back ADD r3 ; ADD r1,r3
    set_id(1, 1, 1, 2, 1, 3, 1, 0);
    #1 chk("prod_nostall", Stall, 0);
    tick();
    set_id(1, 3, 1, 1, 1, 1, 1, 0);
    for (int k = 0; k < EXP; k++) begin
      #1 chk("b2b_stall", Stall, 1);
      chk("b2b_bubble", bubble, 1);
      tick();
    end
    #1 chk("b2b_release", Stall, 0);
    chk("b2b_bubble_off", bubble, 0);
    chk("b2b_cnt", stall_cnt, EXP);
    tick();
    idle(); tick(); tick(); tick();

    // Same specifiers but sources not used
    set_id(1, 0, 0, 0, 0, 2, 1, 0);
    tick();
    set_id(1, 2, 0, 2, 0, 7, 0, 0);
    #1 chk("unused_nostall", Stall, 0);
    id_rt_used = 1;
    #1 chk("rt_used_stall", Stall, 1);
    id_rt_used = 0;
    #1 tick();
    idle(); tick(); tick(); tick();
    chk("unused_cnt", stall_cnt, EXP);

    // Hazard on R0 with mem_busy for two cycles
    set_id(1, 1, 0, 1, 0, 0, 1, 0);
    tick();
    set_id(1, 0, 1, 5, 0, 4, 1, 0);
    #1 chk("busy_pre_stall", Stall, 1);
    chk("busy_pre_bubble", bubble, 1);
    tick();
    mem_busy = 1;
    for (int k = 0; k < 2; k++) begin
      #1 chk("busy_stall", Stall, 1);
      chk("busy_bubble", bubble, 0);
      tick();
    end
    mem_busy = 0;
    for (int k = 0; k < EXP - 1; k++) begin
      #1 chk("busy_post_stall", Stall, 1);
      chk("busy_post_bubble", bubble, 1);
      tick();
    end
    #1 chk("busy_release", Stall, 0);
    chk("busy_cnt", stall_cnt, 2 * EXP + 2);
    tick();
    idle(); tick(); tick(); tick();

    // HALT waits behind a hazard, then drains
    set_id(1, 0, 0, 0, 0, 5, 1, 0);
    tick();
    set_id(1, 5, 1, 0, 0, 0, 0, 1);
    for (int k = 0; k < EXP; k++) begin
      #1 chk("halt_haz_stall", Stall, 1);
      tick();
    end
    #1 chk("halt_accept_nostall", Stall, 0);
    tick();
    idle();
    #1 chk("drain_stall", Stall, 1);
    chk("drain_bubble", bubble, 1);
    chk("drain_hdone0", halt_done, 0);
    tick();
    chk("drain_hdone1", halt_done, 0);
    tick();
    chk("drain_hdone2", halt_done, 0);
    tick();
    chk("hdone_set", halt_done, 1);
    chk("halted_stall", Stall, 1);
    tick(); tick();
    chk("hdone_sticky", halt_done, 1);
    rst = 1'b0;
    #1 chk("rst_clr_hdone", halt_done, 0);
    chk("rst_clr_stall", Stall, 0);
    rst = 1'b1;
    tick();

    // Reset mid-drain discards the drain
    set_id(1, 0, 0, 0, 0, 0, 0, 1);
    #1 chk("halt2_nostall", Stall, 0);
    tick();
    idle();
    #1 chk("halt2_drain_stall", Stall, 1);
    tick();
    rst = 1'b0;
    #1 chk("middrain_hdone", halt_done, 0);
    chk("middrain_stall", Stall, 0);
    chk("middrain_bubble", bubble, 0);
    chk("middrain_cnt", stall_cnt, 0);
    rst = 1'b1;
    tick(); tick(); tick(); tick();
    chk("postrst_hdone", halt_done, 0);
    chk("postrst_stall", Stall, 0);

    // Saturation: hazard frozen by mem_busy
    set_id(1, 0, 0, 0, 0, 6, 1, 0);
    tick();
    set_id(1, 6, 1, 0, 0, 1, 1, 0);
    mem_busy = 1;
    for (int k = 0; k < 70000; k++) @(posedge clk);
    #1 chk("sat_cnt", stall_cnt, 16'hFFFF);
    chk("sat_stall", Stall, 1);
    chk("sat_bubble", bubble, 0);
    mem_busy = 0;
    tick(); tick();
    chk("sat_nowrap", stall_cnt, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
